// File: rtl/aes_frame_buffer.sv
// aes_frame_buffer
// Byte-to-block buffer between an I2C slave byte interface and an AES-128
// controller. It collects 32 bytes (16 key bytes, then 16 plaintext bytes),
// pulses start once, holds key/plaintext stable while the controller runs,
// captures the cipher on done, and serves it back as 16 bytes, MSB first.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   rx_byte/valid     received byte and its one-cycle strobe
//   rx_first          first byte of a write transaction (restarts the frame)
//   tx_req, tx_byte   read strobe and current cipher byte (00 outside READY)
//   chave, palavra    key and plaintext blocks to the controller
//   start             one-cycle registered start pulse
//   cifra, done       cipher from the controller, valid while done is high
//   busy, ready       encryption in flight / cipher held
//   overrun           sticky: a byte arrived while the controller was busy
module aes_frame_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         rx_first,
  input  logic         tx_req,
  output logic [7:0]   tx_byte,
  output logic [127:0] chave,
  output logic [127:0] palavra,
  output logic         start,
  input  logic [127:0] cifra,
  input  logic         done,
  output logic         busy,
  output logic         ready,
  output logic         overrun
);

  typedef enum logic [1:0] {StRx, StGo, StWait, StReady} state_e;

  state_e         state_q;
  logic [4:0]     rx_idx_q;
  logic [3:0]     tx_idx_q;
  logic [127:0]   cipher_q;

  logic [4:0]     wr_idx;
  logic [6:0]     wr_base;
  logic [6:0]     tx_base;

  always_comb begin
    // rx_first with a byte stores it as byte 0 of a fresh frame.
    wr_idx  = rx_first ? 5'd0 : rx_idx_q;
    // Byte n of a block sits at bits [127-8n -: 8]; ~n[3:0] == 15-n.
    wr_base = {~wr_idx[3:0], 3'b000};
    tx_base = {~tx_idx_q, 3'b000};
    tx_byte = (state_q == StReady) ? cipher_q[tx_base +: 8] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StRx;
      rx_idx_q <= 5'd0;
      tx_idx_q <= 4'd0;
      cipher_q <= '0;
      chave    <= '0;
      palavra  <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state_q)
        StRx, StReady: begin
          if (rx_valid) begin
            // A byte in READY drops the held cipher and reopens collection;
            // it also takes priority over a simultaneous tx_req.
            if (wr_idx[4]) begin
              palavra[wr_base +: 8] <= rx_byte;
            end else begin
              chave[wr_base +: 8] <= rx_byte;
            end
            ready <= 1'b0;
            if (wr_idx == 5'd31) begin
              rx_idx_q <= 5'd0;
              state_q  <= StGo;
              start    <= 1'b1;
              busy     <= 1'b1;
            end else begin
              rx_idx_q <= wr_idx + 5'd1;
              state_q  <= StRx;
            end
          end else begin
            if (rx_first) begin
              rx_idx_q <= 5'd0;
            end
            if ((state_q == StReady) && tx_req) begin
              tx_idx_q <= tx_idx_q + 4'd1;
            end
          end
          if (rx_first) begin
            overrun <= 1'b0;
          end
        end
        StGo: begin
          state_q <= StWait;
          if (rx_valid) begin
            overrun <= 1'b1;
          end
        end
        StWait: begin
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (done) begin
            cipher_q <= cifra;
            busy     <= 1'b0;
            ready    <= 1'b1;
            tx_idx_q <= 4'd0;
            state_q  <= StReady;
          end
        end
        default: state_q <= StRx;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_frame_buffer.sv
// Self-checking bench for aes_frame_buffer. A stand-in controller answers
// start pulses after a configurable latency; a frame model predicts key,
// plaintext and cipher bytes, and a negedge monitor checks start pulses and
// consumed tx bytes against queues filled by the stimulus side.
module tb_aes_frame_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_first = 1'b0;
  logic         tx_req = 1'b0;
  logic [7:0]   tx_byte;
  logic [127:0] chave;
  logic [127:0] palavra;
  logic         start;
  logic [127:0] cifra;
  logic         done;
  logic         busy;
  logic         ready;
  logic         overrun;

  always #5 clk = ~clk;

  aes_frame_buffer dut (
    .clk     (clk),
    .rst     (rst),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_first(rx_first),
    .tx_req  (tx_req),
    .tx_byte (tx_byte),
    .chave   (chave),
    .palavra (palavra),
    .start   (start),
    .cifra   (cifra),
    .done    (done),
    .busy    (busy),
    .ready   (ready),
    .overrun (overrun)
  );

  int total = 0;
  int bad   = 0;

  // Frame model (written only by the stimulus process).
  logic [7:0]   m_key[16];
  logic [7:0]   m_pt[16];
  int           m_idx;
  bit           m_busy;
  bit           m_ready;
  bit           m_overrun;
  int           m_tx;
  int           m_dones_seen;
  logic [127:0] m_cipher;
  logic [127:0] m_pend;
  logic [255:0] startq[$];
  logic [7:0]   txq[$];

  // Controller stand-in controls (driven by stimulus, read by controller).
  bit ctrl_hold = 1'b0;
  int ctrl_lat  = 0;
  int stray_cnt = 0;
  // Controller-owned state.
  int c_dones = 0;

  function automatic logic [127:0] ctrl_cipher(input logic [127:0] k, input logic [127:0] p);
    if (k == 128'h000102030405060708090a0b0c0d0e0f &&
        p == 128'h00112233445566778899aabbccddeeff)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_c3c3_0f0f_a5a5_1234_5678_9abc_def0;
  endfunction

  function automatic logic [127:0] vec(input bit pt);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = pt ? m_pt[i] : m_key[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_key[i] = 8'h00;
      m_pt[i]  = 8'h00;
    end
    m_idx = 0; m_busy = 0; m_ready = 0; m_overrun = 0; m_tx = 0;
    m_cipher = '0; m_pend = '0;
    m_dones_seen = c_dones;
    startq.delete();
    txq.delete();
  endtask

  task automatic sync_model();
    if (c_dones != m_dones_seen) begin
      m_dones_seen = c_dones;
      m_busy = 0; m_ready = 1; m_tx = 0; m_cipher = m_pend;
    end
  endtask

  task automatic model_rx(input logic [7:0] b, input bit f);
    if (m_busy) begin
      m_overrun = 1;
      return;
    end
    if (f) begin
      m_idx = 0;
      m_overrun = 0;
    end
    m_ready = 0;
    if (m_idx < 16) m_key[m_idx] = b;
    else m_pt[m_idx-16] = b;
    if (m_idx == 31) begin
      m_idx  = 0;
      m_busy = 1;
      m_pend = ctrl_cipher(vec(0), vec(1));
      startq.push_back({vec(0), vec(1)});
    end else begin
      m_idx++;
    end
  endtask

  // Called at posedge+1; drives one cycle and returns at the next posedge+1.
  task automatic drive(input logic [7:0] b, input bit v, input bit f, input bit t);
    sync_model();
    if (v) begin
      model_rx(b, f);
    end else begin
      if (f && !m_busy) begin
        m_idx = 0;
        m_overrun = 0;
      end
      if (t && m_ready) begin
        txq.push_back(m_cipher[127-8*m_tx -: 8]);
        m_tx = (m_tx + 1) % 16;
      end
    end
    rx_byte = b; rx_valid = v; rx_first = f; tx_req = t;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_first = 1'b0; tx_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    sync_model();
    check("ready_rise", {ready, busy}, 2'b10);
  endtask

  task automatic send_frame(input bit use_first);
    for (int i = 0; i < 32; i++) drive(8'($urandom), 1'b1, use_first && i == 0, 1'b0);
  endtask

  task automatic read_bytes(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_blocks"}, {chave, palavra}, 256'h0);
    check({name, "_flags"}, {start, busy, ready, overrun, tx_byte}, 12'h000);
  endtask

  // Controller stand-in: snapshots the blocks on start, answers after a latency.
  initial begin : controller
    int cnt = 0;
    int stray_seen = 0;
    logic [127:0] ckey = '0;
    logic [127:0] cpt = '0;
    done = 1'b0;
    cifra = '0;
    forever begin
      @(posedge clk); #1;
      done = 1'b0;
      cifra = {$urandom, $urandom, $urandom, $urandom};
      if (!rst) begin
        cnt = 0;
        stray_seen = stray_cnt;
      end else if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        done = 1'b1;
      end else if (start) begin
        ckey = chave;
        cpt  = palavra;
        cnt  = (ctrl_lat > 0) ? ctrl_lat : int'($urandom_range(1, 8));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !ctrl_hold) begin
          done  = 1'b1;
          cifra = ctrl_cipher(ckey, cpt);
          c_dones++;
        end
      end
    end
  end

  // Monitor: checks every start pulse and every consumed tx byte.
  always @(negedge clk) begin : monitor
    logic [255:0] es;
    logic [7:0]   et;
    if (rst) begin
      if (start) begin
        if (startq.size() == 0) begin
          total++; bad++;
          $display("FAIL start_pulse: got start=1 expected start=0");
        end else begin
          es = startq.pop_front();
          check("start_blocks", {chave, palavra}, es);
          check("start_busy", busy, 1'b1);
        end
      end
      if (tx_req && !rx_valid) begin
        if (ready) begin
          if (txq.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got ready=1 with byte %0h expected ready=0", tx_byte);
          end else begin
            et = txq.pop_front();
            check("tx_byte", tx_byte, et);
          end
        end else begin
          check("tx_idle", tx_byte, 8'h00);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Reads before any frame return 00 and must not move the tx index.
    read_bytes(2);

    // Stray done while collecting is ignored.
    stray_cnt++;
    idle(3);
    check("stray_done", {ready, busy, tx_byte}, 10'h000);

    // FIPS-197 C.1 frame.
    for (int i = 0; i < 32; i++)
      drive(i < 16 ? 8'(i) : 8'((i - 16) * 17), 1'b1, i == 0, 1'b0);
    wait_ready();
    check("fips_key", chave, 128'h000102030405060708090a0b0c0d0e0f);
    check("fips_pt", palavra, 128'h00112233445566778899aabbccddeeff);
    read_bytes(17);
    check("fips_ready_hold", ready, 1'b1);

    // Collision: rx wins over tx_req and reopens collection at index 0.
    drive(8'h55, 1'b1, 1'b0, 1'b1);
    check("collide_state", {ready, tx_byte}, 9'h000);
    check("collide_byte", chave[127:120], 8'h55);

    // Abort: partial frame, then rx_first with AA restarts the count.
    for (int i = 0; i < 9; i++) drive(8'($urandom), 1'b1, 1'b0, 1'b0);
    drive(8'hAA, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) drive(8'($urandom), 1'b1, 1'b0, 1'b0);
    wait_ready();
    check("abort_key0", chave[127:120], 8'hAA);
    read_bytes(16);

    // Random frames with random read counts.
    for (int f = 0; f < 4; f++) begin
      send_frame(1'b1);
      wait_ready();
      read_bytes(int'($urandom_range(0, 20)));
    end

    // Overrun: three bytes while the controller runs are dropped.
    ctrl_lat = 10;
    send_frame(1'b1);
    for (int i = 0; i < 3; i++) drive(8'($urandom), 1'b1, 1'b0, 1'b0);
    check("overrun_set", overrun, m_overrun);
    check("overrun_blocks", {chave, palavra}, {vec(0), vec(1)});
    wait_ready();
    read_bytes(16);
    check("overrun_sticky", overrun, 1'b1);
    drive(8'h3C, 1'b1, 1'b1, 1'b0);
    check("overrun_clear", {overrun, ready}, {m_overrun, 1'b0});
    ctrl_lat = 0;

    // Reset mid-WAIT with a controller that never answers.
    ctrl_hold = 1'b1;
    send_frame(1'b1);
    idle(5);
    check("hold_busy", {busy, ready}, 2'b10);
    rst = 1'b0;
    #1;
    check_all_zero("midwait_reset");
    model_reset();
    idle(2);
    rst = 1'b1;
    idle(6);
    check("post_reset_idle", {start, busy, ready}, 3'b000);
    ctrl_hold = 1'b0;

    // After reset the index is 0, so a frame without rx_first completes.
    send_frame(1'b0);
    wait_ready();
    read_bytes(16);

    idle(3);
    check("start_queue_drained", startq.size(), 0);
    check("tx_queue_drained", txq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1);
  end

endmodule
